// File: rtl/sigma_delta_pkg.sv
// rtl/sigma_delta_pkg.sv - shared types, limits and width helper for the sigma-delta ADC
// Contents:
//   out_state_t  output FSM states
//   cic_width()  internal CIC register width for a given ratio and order
//   *_MIN/*_MAX  legal parameter ranges
package sigma_delta_pkg;

   typedef enum logic {IDLE, SEND} out_state_t;

   localparam int CH_MIN     = 1;
   localparam int CH_MAX     = 8;
   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 4;
   localparam int BOSR_MIN   = 4;
   localparam int BOSR_MAX   = 4096;

   // Full scale is bosr**stages, so one extra bit holds it without wrap.
   function automatic int cic_width(input int bosr, input int stages);
      return stages * $clog2(bosr) + 1;
   endfunction

endpackage

// File: rtl/sigma_delta_cic.sv
// rtl/sigma_delta_cic.sv - one channel: CIC integrators, comb chain, clamp and boxcar
// Ports:
//   clk, rst      modulator clock, async active-high reset
//   tick          decimation strobe, high in the last cycle of each frame
//   lvds          comparator bit for this channel
//   sample        decimated, clamped, averaged result (WDTH bits, unsigned)
//   sample_valid  one-cycle strobe, STAGES+2 cycles after tick
module sigma_delta_cic
   import sigma_delta_pkg::*;
#(
   parameter int BOSR    = 1024,
   parameter int STAGES  = 2,
   parameter int WDTH    = 21,
   parameter int BOX_AVG = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            lvds,
   output logic [WDTH-1:0] sample,
   output logic            sample_valid
);

   localparam int WI = cic_width(BOSR, STAGES);
   localparam int LB = $clog2(BOX_AVG);
   localparam int SW = WDTH + LB;

   logic [WI-1:0]   integ  [STAGES];
   logic [WI-1:0]   comb_q [STAGES+1];   // [0] = decimated sample, [k] = k-th difference
   logic [WI-1:0]   comb_d [STAGES];     // previous input of each differentiator
   logic [STAGES:0] strobe;              // strobe[k]: comb_q[k] was updated last edge
   logic [WDTH-1:0] hist   [BOX_AVG];
   logic [SW-1:0]   sum;
   logic [WDTH-1:0] clamped;
   logic            box_valid;

   // Integrators wrap modulo 2**WI; the comb differences undo the wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) integ[k] <= '0;
      end else begin
         integ[0] <= integ[0] + WI'(lvds);
         for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
      end
   end

   // Each differentiator fires one cycle after the previous one, following strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strobe <= '0;
         for (int k = 0; k <= STAGES; k++) comb_q[k] <= '0;
         for (int k = 0; k < STAGES; k++)  comb_d[k] <= '0;
      end else begin
         strobe <= {strobe[STAGES-1:0], tick};
         if (tick) comb_q[0] <= integ[STAGES-1];
         for (int k = 0; k < STAGES; k++) begin
            if (strobe[k]) begin
               comb_q[k+1] <= comb_q[k] - comb_d[k];
               comb_d[k]   <= comb_q[k];
            end
         end
      end
   end

   // Only exact full scale can exceed the output range; saturate it.
   if (WI > WDTH) begin : g_clamp
      assign clamped = (|comb_q[STAGES][WI-1:WDTH]) ? {WDTH{1'b1}} : comb_q[STAGES][WDTH-1:0];
   end else begin : g_extend
      assign clamped = WDTH'(comb_q[STAGES]);
   end

   // Running sum over the last BOX_AVG results; sum always equals the sum of hist.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < BOX_AVG; k++) hist[k] <= '0;
         sum       <= '0;
         box_valid <= 1'b0;
      end else begin
         box_valid <= strobe[STAGES];
         if (strobe[STAGES]) begin
            hist[0] <= clamped;
            for (int k = 1; k < BOX_AVG; k++) hist[k] <= hist[k-1];
            sum <= sum + SW'(clamped) - SW'(hist[BOX_AVG-1]);
         end
      end
   end

   assign sample       = sum[SW-1:LB];
   assign sample_valid = box_valid;

endmodule

// File: rtl/sigma_delta_adc_mc.sv
// rtl/sigma_delta_adc_mc.sv - multi-channel sigma-delta ADC front end with tagged stream output
// Ports:
//   clk, rst       modulator clock, async active-high reset
//   adc_lvds_pin   comparator results, bit i = channel i
//   adc_fb_pin     registered feedback to the RC integrators
//   adc_output     sample of channel adc_channel, valid with adc_valid
//   adc_ready      sink accepts; transfer = adc_valid & adc_ready
//   adc_overrun    sticky: a frame was replaced before it fully drained
module sigma_delta_adc_mc
   import sigma_delta_pkg::*;
#(
   parameter  int CH      = 2,
   parameter  int BOSR    = 1024,
   parameter  int STAGES  = 2,
   parameter  int WDTH    = 21,
   parameter  int BOX_AVG = 8,
   localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CH-1:0]   adc_lvds_pin,
   output logic [CH-1:0]   adc_fb_pin,
   output logic [WDTH-1:0] adc_output,
   output logic [CHW-1:0]  adc_channel,
   output logic            adc_valid,
   input  logic            adc_ready,
   output logic            adc_overrun
);

   localparam int CW     = $clog2(BOSR);
   localparam int SETTLE = STAGES + BOX_AVG - 1;
   localparam int SCW    = $clog2(SETTLE + 1);

   if (CH < CH_MIN || CH > CH_MAX || STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
       BOSR < BOSR_MIN || BOSR > BOSR_MAX || (BOSR & (BOSR - 1)) != 0 ||
       CH > BOSR - STAGES - 3) begin : g_bad_cfg
      $error("sigma_delta_adc_mc: illegal parameter combination");
   end

   logic [CW-1:0]   count;
   logic            tick;
   logic [SCW-1:0]  settle_cnt;
   logic            settled;
   logic            load;
   logic [WDTH-1:0] sample [CH];
   logic [CH-1:0]   sample_valid;
   logic [WDTH-1:0] bank   [CH];
   out_state_t      state, state_n;
   logic [CHW-1:0]  idx, idx_n;
   logic            overrun_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) adc_fb_pin <= '0;
      else     adc_fb_pin <= adc_lvds_pin;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else     count <= count + 1'b1;
   end
   assign tick = (count == CW'(BOSR - 1));

   for (genvar i = 0; i < CH; i++) begin : g_ch
      sigma_delta_cic #(
         .BOSR(BOSR), .STAGES(STAGES), .WDTH(WDTH), .BOX_AVG(BOX_AVG)
      ) u_cic (
         .clk(clk), .rst(rst), .tick(tick), .lvds(adc_lvds_pin[i]),
         .sample(sample[i]), .sample_valid(sample_valid[i])
      );
   end

   // All channels share the tick, so their valid strobes are identical.
   assign settled = (settle_cnt == SCW'(SETTLE));
   assign load    = (&sample_valid) && settled;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt <= '0;
         for (int i = 0; i < CH; i++) bank[i] <= '0;
      end else begin
         if ((&sample_valid) && !settled) settle_cnt <= settle_cnt + 1'b1;
         if (load) begin
            for (int i = 0; i < CH; i++) bank[i] <= sample[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         adc_overrun <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         adc_overrun <= overrun_n;
      end
   end

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      overrun_n   = adc_overrun;
      adc_valid   = (state == SEND);
      adc_output  = bank[idx];
      adc_channel = idx;
      case (state)
         IDLE: begin
            if (load) begin
               state_n = SEND;
               idx_n   = '0;
            end
         end
         SEND: begin
            if (load) begin
               // Handing over the last channel as the new frame lands is on time.
               idx_n = '0;
               if (!(adc_ready && idx == CHW'(CH - 1))) overrun_n = 1'b1;
            end else if (adc_ready) begin
               if (idx == CHW'(CH - 1)) begin
                  state_n = IDLE;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sigma_delta_adc_mc.sv
// tb/tb_sigma_delta_adc_mc.sv - scoreboard bench: main config, boxcar config, clamp config
module tb_sigma_delta_adc_mc;

   typedef struct { int ch; int data; } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst_a = 1'b1;
   logic       ready = 1'b1;
   logic       ready_a = 1'b1;
   logic [1:0] lvds = 2'b00, lvds_b = 2'b00, lvds_c = 2'b00;
   logic [1:0] fb, fb_b, fb_c;
   logic [8:0] m_out, b_out;
   logic [7:0] c_out;
   logic [0:0] m_ch, b_ch, c_ch;
   logic       m_valid, b_valid, c_valid;
   logic       m_ovr, b_ovr, c_ovr;

   exp_t q_main[$], q_box[$], q_clamp[$];
   int   compared = 0;
   int   mismatched = 0;
   logic toggle_en = 1'b0;
   logic fb_armed = 1'b0;
   logic [1:0] lvds_edge = 2'b00;

   always #5 clk = ~clk;

   sigma_delta_adc_mc #(.CH(2), .BOSR(16), .STAGES(2), .WDTH(9), .BOX_AVG(1)) u_main (
      .clk(clk), .rst(rst), .adc_lvds_pin(lvds), .adc_fb_pin(fb), .adc_output(m_out),
      .adc_channel(m_ch), .adc_valid(m_valid), .adc_ready(ready), .adc_overrun(m_ovr));

   sigma_delta_adc_mc #(.CH(2), .BOSR(16), .STAGES(2), .WDTH(9), .BOX_AVG(4)) u_box (
      .clk(clk), .rst(rst_a), .adc_lvds_pin(lvds_b), .adc_fb_pin(fb_b), .adc_output(b_out),
      .adc_channel(b_ch), .adc_valid(b_valid), .adc_ready(ready_a), .adc_overrun(b_ovr));

   sigma_delta_adc_mc #(.CH(2), .BOSR(16), .STAGES(2), .WDTH(8), .BOX_AVG(1)) u_clamp (
      .clk(clk), .rst(rst_a), .adc_lvds_pin(lvds_c), .adc_fb_pin(fb_c), .adc_output(c_out),
      .adc_channel(c_ch), .adc_valid(c_valid), .adc_ready(ready_a), .adc_overrun(c_ovr));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void push_main(input int c, input int d);
      q_main.push_back('{c, d});
   endfunction

   // Scoreboard monitor: every accepted beat is compared with the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && m_valid && ready && q_main.size() > 0) begin
         e = q_main.pop_front();
         check("main_tag", 32'(m_ch), e.ch);
         check("main_data", 32'(m_out), e.data);
      end
      if (!rst_a && b_valid && ready_a && q_box.size() > 0) begin
         e = q_box.pop_front();
         check("box_tag", 32'(b_ch), e.ch);
         check("box_data", 32'(b_out), e.data);
      end
      if (!rst_a && c_valid && ready_a && q_clamp.size() > 0) begin
         e = q_clamp.pop_front();
         check("clamp_tag", 32'(c_ch), e.ch);
         check("clamp_data", 32'(c_out), e.data);
      end
   end

   // Feedback must be the comparator bit seen at the previous rising edge.
   always @(posedge clk) begin
      lvds_edge <= lvds;
      fb_armed  <= toggle_en && !rst;
   end
   always @(negedge clk) begin
      if (fb_armed && !rst) check("fb_delay", 32'(fb), 32'(lvds_edge));
   end

   always @(posedge clk) begin
      if (toggle_en) #1 lvds[0] = ~lvds[0];
   end

   task automatic drain_main(input int budget);
      int n = 0;
      while (q_main.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("main_drain_left", q_main.size(), 0);
   endtask

   task automatic wait_main(input logic want_valid, input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (m_valid !== want_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(m_valid), 32'(want_valid));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int first;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(m_valid), 0);
      check("rst_fb", 32'(fb), 0);
      check("rst_output", 32'(m_out), 0);
      check("rst_channel", 32'(m_ch), 0);
      check("rst_overrun", 32'(m_ovr), 0);

      // Constant input: ch0 full scale, ch1 zero, tags in order.
      lvds = 2'b01;
      rst  = 1'b0;
      for (int f = 0; f < 4; f++) begin
         push_main(0, 256);
         push_main(1, 0);
      end
      drain_main(400);
      check("no_overrun_streaming", 32'(m_ovr), 0);

      // Stall after ch0 of a frame has gone, across two frame loads.
      wait_main(1'b0, 40, "idle_before_stall");
      push_main(0, 256);
      n = 0;
      @(negedge clk);
      while (!(m_valid && m_ch == 1'b0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("stall_start_found", 32'(m_valid && m_ch == 1'b0), 1);
      @(posedge clk);
      #1 ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_hold_valid", 32'(m_valid), 1);
         check("stall_hold_tag", 32'(m_ch), 1);
         check("stall_hold_data", 32'(m_out), 0);
         check("stall_no_overrun_yet", 32'(m_ovr), 0);
      end
      repeat (34) @(negedge clk);
      check("overrun_set", 32'(m_ovr), 1);
      check("overrun_valid_kept", 32'(m_valid), 1);
      check("overrun_idx_restart", 32'(m_ch), 0);
      check("overrun_new_data", 32'(m_out), 256);
      push_main(0, 256);
      push_main(1, 0);
      @(posedge clk);
      #1 ready = 1'b1;
      drain_main(100);
      check("overrun_sticky", 32'(m_ovr), 1);

      // Reset while a frame is being sent, then toggling ch0.
      wait_main(1'b1, 40, "send_before_reset");
      #1 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(m_valid), 0);
      check("async_rst_fb", 32'(fb), 0);
      check("async_rst_overrun", 32'(m_ovr), 0);
      check("async_rst_output", 32'(m_out), 0);
      lvds      = 2'b00;
      toggle_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int f = 0; f < 4; f++) begin
         push_main(0, 128);
         push_main(1, 0);
      end
      // Frames 0 and 1 are discarded; frame 2 ticks in cycle 47 and loads 4 cycles later.
      first = 0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (m_valid && first == 0) first = k;
      end
      check("settle_first_valid_cycle", first, 52);
      drain_main(200);
      toggle_en = 1'b0;

      // Boxcar step and clamp configurations.
      lvds_c = 2'b01;
      @(negedge clk);
      rst_a = 1'b0;
      for (int f = 0; f < 3; f++) begin
         q_clamp.push_back('{0, 255});
         q_clamp.push_back('{1, 0});
      end
      for (int f = 0; f < 3; f++) begin
         q_box.push_back('{0, 0});
         q_box.push_back('{1, 0});
      end
      // Step lands in the tick cycle of frame 7: CIC gives 120 then 256; boxcar of 4 averages.
      q_box.push_back('{0, 30});  q_box.push_back('{1, 0});
      q_box.push_back('{0, 94});  q_box.push_back('{1, 0});
      q_box.push_back('{0, 158}); q_box.push_back('{1, 0});
      q_box.push_back('{0, 222}); q_box.push_back('{1, 0});
      q_box.push_back('{0, 256}); q_box.push_back('{1, 0});
      q_box.push_back('{0, 256}); q_box.push_back('{1, 0});
      repeat (127) @(posedge clk);
      #1 lvds_b = 2'b01;
      n = 0;
      while ((q_box.size() > 0 || q_clamp.size() > 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("box_drain_left", q_box.size(), 0);
      check("clamp_drain_left", q_clamp.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
